// File: rtl/intm_rs_pkg.sv
// Shared types and widths for the integer multiply/divide reservation station.
// Holds the entry format stored in each slot, the issue payload handed to the
// multiply/divide unit, and the M-extension opcode encoding.
package intm_rs_pkg;

    localparam int XLEN           = 32;
    localparam int ROB_IDX_WIDTH  = 6;
    localparam int PRF_IDX_WIDTH  = 6;
    localparam int ARCH_IDX_WIDTH = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } fu_opcode_t;

    typedef struct packed {
        logic [ROB_IDX_WIDTH-1:0]  rob_id;
        logic [ARCH_IDX_WIDTH-1:0] rd_arch;
        logic [PRF_IDX_WIDTH-1:0]  rd_phy;
        fu_opcode_t                fu_opcode;
        logic [PRF_IDX_WIDTH-1:0]  rs1_phy;
        logic                      rs1_ready;
        logic [XLEN-1:0]           rs1_value;
        logic [PRF_IDX_WIDTH-1:0]  rs2_phy;
        logic                      rs2_ready;
        logic [XLEN-1:0]           rs2_value;
    } intm_rs_entry_t;

    typedef struct packed {
        logic [ROB_IDX_WIDTH-1:0]  rob_id;
        logic [ARCH_IDX_WIDTH-1:0] rd_arch;
        logic [PRF_IDX_WIDTH-1:0]  rd_phy;
        fu_opcode_t                fu_opcode;
        logic [XLEN-1:0]           rs1_value;
        logic [XLEN-1:0]           rs2_value;
    } intm_rs_reg_t;

    // p0 is the hardwired zero register: it is always ready and never a wakeup tag.
    function automatic logic is_p0(input logic [PRF_IDX_WIDTH-1:0] phy);
        return (phy == '0);
    endfunction

endpackage

// File: rtl/cdb_itf.sv
// One common data bus broadcast port. Producers drive it through the source
// modport; reservation stations only watch it through the monitor modport.
interface cdb_itf;
    import intm_rs_pkg::*;

    logic                     valid;
    logic [PRF_IDX_WIDTH-1:0] rd_phy;
    logic [XLEN-1:0]          rd_value;

    modport source  (output valid, output rd_phy, output rd_value);
    modport monitor (input  valid, input  rd_phy, input  rd_value);

endinterface

// File: rtl/intm_rs_age_matrix.sv
// Age matrix for oldest-first select. r_older[i][j] is set when slot i was
// written before slot j. A newly allocated slot is younger than every slot
// currently valid, so its row is cleared and its column copies valid_vec.
// Bits belonging to free slots may be stale; they are harmless because a
// free slot never requests and is rewritten on its next allocation.
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_en,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  logic [DEPTH-1:0]         valid_vec,
    input  logic [DEPTH-1:0]         req_vec,
    output logic [DEPTH-1:0]         grant_vec
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DEPTH-1:0] r_older;
    logic [DEPTH-1:0]            w_blocked;

    // Record relative age of a newly allocated slot against all resident slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_older <= '0;
        end else if (alloc_en) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_older[alloc_idx][j] <= 1'b0;
                if (IDX_W'(j) != alloc_idx) begin
                    r_older[j][alloc_idx] <= valid_vec[j];
                end
            end
        end
    end

    // A requester is blocked when any other requester is older than it.
    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && req_vec[j] && r_older[j][i]) begin
                    w_blocked[i] = 1'b1;
                end
            end
        end
    end

    assign grant_vec = req_vec & ~w_blocked;

endmodule

// File: rtl/intm_rs.sv
// Integer multiply/divide reservation station. Holds dispatched M-extension
// uops until both sources are available (captured at dispatch or snooped off
// the CDBs), then hands the oldest ready one to the mul/div unit over a
// valid/ready handshake. Issue payload is combinational from stored state,
// so a woken entry can issue no earlier than the cycle after its broadcast.
module intm_rs
    import intm_rs_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           dispatch_valid,
    output logic           dispatch_ready,
    input  intm_rs_entry_t dispatch_entry,
    cdb_itf.monitor        cdb [NUM_CDB],
    output logic           issue_valid,
    input  logic           issue_ready,
    output intm_rs_reg_t   issue_out
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] r_valid;
    intm_rs_entry_t   r_entry [DEPTH];

    logic                     w_cdbValid [NUM_CDB];
    logic [PRF_IDX_WIDTH-1:0] w_cdbTag   [NUM_CDB];
    logic [XLEN-1:0]          w_cdbValue [NUM_CDB];

    intm_rs_entry_t   w_dispEntry;
    intm_rs_entry_t   w_nextEntry [DEPTH];
    logic [IDX_W-1:0] w_allocIdx;
    logic             w_dispatchFire;
    logic [DEPTH-1:0] w_reqVec;
    logic [DEPTH-1:0] w_grantVec;
    logic             w_issueFire;

    // Flatten the CDB interface array into plain arrays for loop-indexed compares.
    for (genvar c = 0; c < NUM_CDB; c++) begin : g_cdb
        assign w_cdbValid[c] = cdb[c].valid;
        assign w_cdbTag[c]   = cdb[c].rd_phy;
        assign w_cdbValue[c] = cdb[c].rd_value;
    end

    assign dispatch_ready = |(~r_valid);
    assign w_dispatchFire = dispatch_valid && dispatch_ready && !flush;

    // Lowest-index free slot receives the next dispatched uop.
    always_comb begin
        w_allocIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_allocIdx = IDX_W'(i);
            end
        end
    end

    // Sanitise the incoming uop: p0 sources become ready zero, and a CDB hit in
    // the dispatch cycle is folded in so that broadcast is not missed.
    always_comb begin
        w_dispEntry = dispatch_entry;
        if (is_p0(dispatch_entry.rs1_phy)) begin
            w_dispEntry.rs1_ready = 1'b1;
            w_dispEntry.rs1_value = '0;
        end else if (!dispatch_entry.rs1_ready) begin
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (w_cdbValid[c] && (w_cdbTag[c] == dispatch_entry.rs1_phy)) begin
                    w_dispEntry.rs1_ready = 1'b1;
                    w_dispEntry.rs1_value = w_cdbValue[c];
                end
            end
        end
        if (is_p0(dispatch_entry.rs2_phy)) begin
            w_dispEntry.rs2_ready = 1'b1;
            w_dispEntry.rs2_value = '0;
        end else if (!dispatch_entry.rs2_ready) begin
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (w_cdbValid[c] && (w_cdbTag[c] == dispatch_entry.rs2_phy)) begin
                    w_dispEntry.rs2_ready = 1'b1;
                    w_dispEntry.rs2_value = w_cdbValue[c];
                end
            end
        end
    end

    // Wakeup for resident entries; scanning downward lets the lowest CDB port win.
    always_comb begin
        w_nextEntry = r_entry;
        for (int e = 0; e < DEPTH; e++) begin
            if (!r_entry[e].rs1_ready && !is_p0(r_entry[e].rs1_phy)) begin
                for (int c = NUM_CDB - 1; c >= 0; c--) begin
                    if (w_cdbValid[c] && (w_cdbTag[c] == r_entry[e].rs1_phy)) begin
                        w_nextEntry[e].rs1_ready = 1'b1;
                        w_nextEntry[e].rs1_value = w_cdbValue[c];
                    end
                end
            end
            if (!r_entry[e].rs2_ready && !is_p0(r_entry[e].rs2_phy)) begin
                for (int c = NUM_CDB - 1; c >= 0; c--) begin
                    if (w_cdbValid[c] && (w_cdbTag[c] == r_entry[e].rs2_phy)) begin
                        w_nextEntry[e].rs2_ready = 1'b1;
                        w_nextEntry[e].rs2_value = w_cdbValue[c];
                    end
                end
            end
        end
    end

    // Candidates are valid entries with both operands in hand.
    always_comb begin
        w_reqVec = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_reqVec[e] = r_valid[e] && r_entry[e].rs1_ready && r_entry[e].rs2_ready;
        end
    end

    rs_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (w_dispatchFire),
        .alloc_idx (w_allocIdx),
        .valid_vec (r_valid),
        .req_vec   (w_reqVec),
        .grant_vec (w_grantVec)
    );

    assign issue_valid = |w_reqVec;
    assign w_issueFire = issue_valid && issue_ready;

    // Present the granted entry's payload; the grant is one-hot so at most one hit.
    always_comb begin
        issue_out = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (w_grantVec[e]) begin
                issue_out.rob_id    = r_entry[e].rob_id;
                issue_out.rd_arch   = r_entry[e].rd_arch;
                issue_out.rd_phy    = r_entry[e].rd_phy;
                issue_out.fu_opcode = r_entry[e].fu_opcode;
                issue_out.rs1_value = r_entry[e].rs1_value;
                issue_out.rs2_value = r_entry[e].rs2_value;
            end
        end
    end

    // Slot occupancy: flush empties everything, otherwise allocate and free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_dispatchFire && (w_allocIdx == IDX_W'(e))) begin
                    r_valid[e] <= 1'b1;
                end else if (w_issueFire && w_grantVec[e]) begin
                    r_valid[e] <= 1'b0;
                end
            end
        end
    end

    // Entry payload has no reset; it is meaningful only while the slot is valid.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (w_dispatchFire && (w_allocIdx == IDX_W'(e))) begin
                r_entry[e] <= w_dispEntry;
            end else begin
                r_entry[e] <= w_nextEntry[e];
            end
        end
    end

endmodule

// File: tb/tb_intm_rs.sv
// Directed bench for the mul/div reservation station: single issue, CDB wakeup,
// dispatch-cycle wakeup, age ordering, full/backpressure and flush behaviour.
module tb_intm_rs;
    import intm_rs_pkg::*;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           dispatchValid;
    logic           dispatchReady;
    intm_rs_entry_t dispatchEntry;
    logic           issueValid;
    logic           issueReady;
    intm_rs_reg_t   issueOut;

    int checks;
    int failures;

    cdb_itf cdbBus [4] ();

    intm_rs #(
        .DEPTH   (4),
        .NUM_CDB (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .dispatch_valid (dispatchValid),
        .dispatch_ready (dispatchReady),
        .dispatch_entry (dispatchEntry),
        .cdb            (cdbBus),
        .issue_valid    (issueValid),
        .issue_ready    (issueReady),
        .issue_out      (issueOut)
    );

    // Free-running clock, active edge is posedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic intm_rs_entry_t makeEntry(
        input int         rob,
        input fu_opcode_t op,
        input int         rs1Phy,
        input logic       rs1Rdy,
        input int         rs1Val,
        input int         rs2Phy,
        input logic       rs2Rdy,
        input int         rs2Val
    );
        intm_rs_entry_t e;
        e.rob_id    = ROB_IDX_WIDTH'(rob);
        e.rd_arch   = ARCH_IDX_WIDTH'(rob);
        e.rd_phy    = PRF_IDX_WIDTH'(rob + 1);
        e.fu_opcode = op;
        e.rs1_phy   = PRF_IDX_WIDTH'(rs1Phy);
        e.rs1_ready = rs1Rdy;
        e.rs1_value = XLEN'(rs1Val);
        e.rs2_phy   = PRF_IDX_WIDTH'(rs2Phy);
        e.rs2_ready = rs2Rdy;
        e.rs2_value = XLEN'(rs2Val);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input intm_rs_entry_t e);
        dispatchValid = valid;
        dispatchEntry = e;
    endtask

    task automatic setCdb(input int port, input logic v, input int tag, input int value);
        case (port)
            0: begin cdbBus[0].valid = v; cdbBus[0].rd_phy = PRF_IDX_WIDTH'(tag); cdbBus[0].rd_value = XLEN'(value); end
            1: begin cdbBus[1].valid = v; cdbBus[1].rd_phy = PRF_IDX_WIDTH'(tag); cdbBus[1].rd_value = XLEN'(value); end
            2: begin cdbBus[2].valid = v; cdbBus[2].rd_phy = PRF_IDX_WIDTH'(tag); cdbBus[2].rd_value = XLEN'(value); end
            default: begin cdbBus[3].valid = v; cdbBus[3].rd_phy = PRF_IDX_WIDTH'(tag); cdbBus[3].rd_value = XLEN'(value); end
        endcase
    endtask

    task automatic clearCdb();
        for (int p = 0; p < 4; p++) begin
            setCdb(p, 1'b0, 0, 0);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    intm_rs_entry_t idle;

    initial begin
        checks        = 0;
        failures      = 0;
        idle          = makeEntry(0, OP_MUL, 0, 1'b0, 0, 0, 1'b0, 0);
        rst           = 1'b1;
        flush         = 1'b0;
        issueReady    = 1'b0;
        applyStimulus(1'b0, idle);
        clearCdb();
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_dispatch_ready", 32'(dispatchReady), 32'd1);
        checkOutput("rst_issue_valid", 32'(issueValid), 32'd0);

        $display("[TB] single issue");
        issueReady = 1'b1;
        applyStimulus(1'b1, makeEntry(1, OP_MUL, 1, 1'b1, 7, 2, 1'b1, 6));
        tick();
        applyStimulus(1'b0, idle);
        checkOutput("t1_issue_valid", 32'(issueValid), 32'd1);
        checkOutput("t1_rs1", issueOut.rs1_value, 32'd7);
        checkOutput("t1_rs2", issueOut.rs2_value, 32'd6);
        checkOutput("t1_rob", 32'(issueOut.rob_id), 32'd1);
        checkOutput("t1_op", 32'(issueOut.fu_opcode), 32'(OP_MUL));
        tick();
        checkOutput("t1_freed_valid", 32'(issueValid), 32'd0);
        checkOutput("t1_freed_ready", 32'(dispatchReady), 32'd1);

        $display("[TB] CDB wakeup");
        applyStimulus(1'b1, makeEntry(2, OP_DIV, 12, 1'b0, 0, 0, 1'b0, 32'h55));
        tick();
        applyStimulus(1'b0, idle);
        checkOutput("t2_wait0", 32'(issueValid), 32'd0);
        tick();
        checkOutput("t2_wait1", 32'(issueValid), 32'd0);
        setCdb(2, 1'b1, 12, 100);
        tick();
        clearCdb();
        checkOutput("t2_issue_valid", 32'(issueValid), 32'd1);
        checkOutput("t2_rs1", issueOut.rs1_value, 32'd100);
        checkOutput("t2_rs2_p0", issueOut.rs2_value, 32'd0);
        checkOutput("t2_op", 32'(issueOut.fu_opcode), 32'(OP_DIV));
        tick();
        checkOutput("t2_freed", 32'(issueValid), 32'd0);

        $display("[TB] dispatch-cycle wakeup");
        applyStimulus(1'b1, makeEntry(3, OP_MULH, 1, 1'b1, 3, 5, 1'b0, 0));
        setCdb(0, 1'b1, 5, 32'hDEAD);
        setCdb(1, 1'b1, 5, 32'hDEAD);
        setCdb(3, 1'b1, 0, 32'h77);
        tick();
        applyStimulus(1'b0, idle);
        clearCdb();
        checkOutput("t3_issue_valid", 32'(issueValid), 32'd1);
        checkOutput("t3_rs2", issueOut.rs2_value, 32'hDEAD);
        checkOutput("t3_rs1", issueOut.rs1_value, 32'd3);
        tick();
        checkOutput("t3_freed", 32'(issueValid), 32'd0);

        $display("[TB] age order, staggered wakeup");
        issueReady = 1'b0;
        applyStimulus(1'b1, makeEntry(10, OP_MUL, 3, 1'b0, 0, 1, 1'b1, 1));
        tick();
        applyStimulus(1'b1, makeEntry(11, OP_MUL, 4, 1'b0, 0, 1, 1'b1, 1));
        tick();
        applyStimulus(1'b1, makeEntry(12, OP_MUL, 1, 1'b1, 5, 1, 1'b1, 1));
        tick();
        applyStimulus(1'b0, idle);
        checkOutput("t4_first_rob", 32'(issueOut.rob_id), 32'd12);
        issueReady = 1'b1;
        setCdb(0, 1'b1, 4, 44);
        tick();
        clearCdb();
        checkOutput("t4_second_rob", 32'(issueOut.rob_id), 32'd11);
        checkOutput("t4_second_rs1", issueOut.rs1_value, 32'd44);
        setCdb(0, 1'b1, 3, 33);
        tick();
        clearCdb();
        checkOutput("t4_third_rob", 32'(issueOut.rob_id), 32'd10);
        checkOutput("t4_third_rs1", issueOut.rs1_value, 32'd33);
        tick();
        checkOutput("t4_drained", 32'(issueValid), 32'd0);

        $display("[TB] age order, simultaneous wakeup with older entry in higher slot");
        issueReady = 1'b0;
        applyStimulus(1'b1, makeEntry(20, OP_REM, 1, 1'b1, 9, 2, 1'b1, 9));
        tick();
        applyStimulus(1'b1, makeEntry(21, OP_REM, 3, 1'b0, 0, 2, 1'b1, 2));
        tick();
        applyStimulus(1'b0, idle);
        checkOutput("t4b_d1_rob", 32'(issueOut.rob_id), 32'd20);
        issueReady = 1'b1;
        tick();
        checkOutput("t4b_d1_gone", 32'(issueValid), 32'd0);
        issueReady = 1'b0;
        applyStimulus(1'b1, makeEntry(22, OP_REM, 4, 1'b0, 0, 2, 1'b1, 2));
        tick();
        applyStimulus(1'b0, idle);
        setCdb(0, 1'b1, 4, 32'h41);
        setCdb(1, 1'b1, 3, 32'h31);
        issueReady = 1'b1;
        tick();
        clearCdb();
        checkOutput("t4b_a_rob", 32'(issueOut.rob_id), 32'd21);
        checkOutput("t4b_a_rs1", issueOut.rs1_value, 32'h31);
        tick();
        checkOutput("t4b_b_rob", 32'(issueOut.rob_id), 32'd22);
        checkOutput("t4b_b_rs1", issueOut.rs1_value, 32'h41);
        tick();
        checkOutput("t4b_drained", 32'(issueValid), 32'd0);

        $display("[TB] full with backpressure");
        issueReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, makeEntry(30 + k, OP_DIVU, 1, 1'b1, k, 2, 1'b1, k));
            tick();
        end
        applyStimulus(1'b1, makeEntry(34, OP_DIVU, 1, 1'b1, 1, 2, 1'b1, 1));
        checkOutput("t5_full_ready", 32'(dispatchReady), 32'd0);
        checkOutput("t5_head_rob", 32'(issueOut.rob_id), 32'd30);
        tick();
        checkOutput("t5_still_full", 32'(dispatchReady), 32'd0);
        checkOutput("t5_stable_rob", 32'(issueOut.rob_id), 32'd30);
        issueReady = 1'b1;
        tick();
        issueReady = 1'b0;
        applyStimulus(1'b0, idle);
        checkOutput("t5_freed_ready", 32'(dispatchReady), 32'd1);
        checkOutput("t5_next_rob", 32'(issueOut.rob_id), 32'd31);
        issueReady = 1'b1;
        tick();
        checkOutput("t5_rob32", 32'(issueOut.rob_id), 32'd32);
        tick();
        checkOutput("t5_rob33", 32'(issueOut.rob_id), 32'd33);
        tick();
        checkOutput("t5_extra_dropped", 32'(issueValid), 32'd0);

        $display("[TB] flush");
        issueReady = 1'b0;
        applyStimulus(1'b1, makeEntry(40, OP_MUL, 7, 1'b0, 0, 1, 1'b1, 1));
        tick();
        applyStimulus(1'b1, makeEntry(41, OP_MUL, 8, 1'b0, 0, 1, 1'b1, 1));
        tick();
        applyStimulus(1'b1, makeEntry(42, OP_MUL, 1, 1'b1, 1, 1, 1'b1, 1));
        tick();
        checkOutput("t6_pre_rob", 32'(issueOut.rob_id), 32'd42);
        applyStimulus(1'b1, makeEntry(43, OP_MUL, 1, 1'b1, 1, 1, 1'b1, 1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, idle);
        checkOutput("t6_issue_valid", 32'(issueValid), 32'd0);
        checkOutput("t6_dispatch_ready", 32'(dispatchReady), 32'd1);
        setCdb(0, 1'b1, 7, 70);
        setCdb(1, 1'b1, 8, 80);
        issueReady = 1'b1;
        tick();
        clearCdb();
        checkOutput("t6_no_wake_issue", 32'(issueValid), 32'd0);
        tick();
        checkOutput("t6_still_empty", 32'(issueValid), 32'd0);
        applyStimulus(1'b1, makeEntry(50, OP_REMU, 1, 1'b1, 5, 2, 1'b1, 6));
        tick();
        applyStimulus(1'b0, idle);
        checkOutput("t6_post_rob", 32'(issueOut.rob_id), 32'd50);
        tick();
        checkOutput("t6_post_drained", 32'(issueValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
